countdown_timer_ctrl: RTL and testbench
=======================================

// Module: countdown_timer_ctrl
// PURPOSE
//  Parametrised countdown-timer controller: N cascaded BCD-free binary fields (default MM:SS),
//  field-by-field entry from switches, internal 1 Hz prescaler, borrow-chain decrement,
//  pause/resume and flashing alarm. Sits between debounced/edge-detected buttons and display logic.
// PARAMETERS
//  NUM_FIELDS  2         number of time fields; field 0 least significant (secs, mins, ...)
//  FIELD_W     7         bits per field
//  FIELD_MAX   59        max value of every field; wrap target on borrow
//  TICK_DIV    50000000  clk cycles per decrement tick (>=2)
//  FLASH_DIV   12500000  clk cycles per flashOn toggle (>=1)
//  FLASH_SECS  10        ticks before auto-exit from FLASH (only with FLASH_TIMEOUT_EN)
// PORTS
//  clk        in   1                     system clock
//  reset      in   1                     asynchronous active-low reset
//  clear      in   1                     synchronous soft clear, 1-cycle pulse
//  set        in   1                     set button, 1-cycle pulse
//  startStop  in   1                     start/stop button, 1-cycle pulse
//  swValue    in   FIELD_W               switch value for field being edited
//  timeBus    out  NUM_FIELDS*FIELD_W    current time, field k at [k*FIELD_W +: FIELD_W]
//  editIdx    out  max(1,clog2(NUM_FIELDS)) field index being edited
//  fieldSet   out  NUM_FIELDS            1-cycle strobe: field k just loaded
//  state      out  3                     IDLE=0 SET=1 READY=2 RUN=3 FLASH=4
//  running    out  1                     1 while state==RUN
//  isTimeFlat out  1                     1 when all fields are zero (registered)
//  flashOn    out  1                     alarm LED drive; toggles in FLASH, else 0
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, all fields 0, editIdx 0, fieldSet 0, prescaler 0,
//   flash counter 0, flashOn 0, running 0, isTimeFlat 1. All outputs registered.
//  Sync priority per cycle: clear > expiry > startStop > set > tick.
//  clear: any state -> IDLE, fields 0, editIdx 0, prescaler 0, flashOn 0, next edge.
//  IDLE: set -> SET, editIdx=0. startStop ignored.
//  SET: set loads field[editIdx] <= min(swValue,FIELD_MAX), fieldSet[editIdx]=1 for the next
//   cycle only; editIdx++; after loading last field -> READY, editIdx=0. startStop ignored.
//  READY: startStop -> RUN if !isTimeFlat; ignored if time is zero. set -> SET, editIdx=0,
//   fields retained until overwritten. Prescaler holds its value (pause keeps partial second).
//  RUN: prescaler counts 0..TICK_DIV-1; tick asserted on terminal count, prescaler -> 0.
//   On tick: field0 decrements; a field at 0 wraps to FIELD_MAX and borrows from field k+1.
//   Top field never borrows (all-zero detected first). Decrement visible on timeBus 1 cycle
//   after the tick edge.
//   Expiry: tick that makes all fields zero -> FLASH same edge, isTimeFlat=1 same edge.
//   startStop -> READY; if startStop coincides with a tick, the decrement still applies;
//   if that decrement expires the timer, FLASH wins over READY.
//   set ignored in RUN.
//  FLASH: flashOn starts at 1 on entry, toggles every FLASH_DIV cycles. startStop or set
//   -> IDLE, fields stay 0, flashOn 0 next edge. Prescaler keeps running for timeout use.
//  isTimeFlat recomputed from next-state field values; valid in every state.
//  Reset asserted mid-RUN/FLASH aborts immediately; no pending strobe survives.
// CONFIGURATION
//  FLASH_TIMEOUT_EN defined: FLASH counts prescaler ticks; after FLASH_SECS ticks -> IDLE,
//   flashOn 0. User exit (startStop/set/clear) still honoured earlier.
//  FLASH_TIMEOUT_EN undefined: FLASH held until startStop, set, clear or reset; FLASH_SECS unused.
// TESTING (bench uses NUM_FIELDS=2, FIELD_MAX=59, TICK_DIV=4, FLASH_DIV=2, FLASH_SECS=3)
//  Entry: set; swValue=5,set; swValue=1,set -> fieldSet=01 then 10, state READY, timeBus={1,5}.
//  Saturation: swValue=100 on field0 load -> field0=59.
//  Borrow: load {1,0}, startStop -> after 4 cycles timeBus={0,59}; 59 further ticks -> FLASH,
//   isTimeFlat=1, flashOn toggles every 2 cycles.
//  Pause: RUN {0,10}, startStop after 2 cycles -> READY, time {0,10}; startStop -> decrement
//   to {0,9} after 2 more cycles (partial prescaler kept).
//  Corners: startStop in READY with {0,0} -> stays READY; startStop on same cycle as final tick
//   -> FLASH; clear in RUN -> IDLE, timeBus=0; reset low mid-FLASH -> all outputs reset values.
//  Macro: with FLASH_TIMEOUT_EN, FLASH -> IDLE after 12 cycles; without, FLASH held 100 cycles.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: countdown timer controller with field-by-field entry,
// an internal tick prescaler, a borrow-chain decrement, pause/resume and a
// flashing alarm. State codes: IDLE=0 SET=1 READY=2 RUN=3 FLASH=4.
// Optional build macro FLASH_TIMEOUT_EN: when defined, FLASH leaves to IDLE by
// itself after FLASH_SECS ticks; when undefined, FLASH is held until the user
// exits it and FLASH_SECS is unused.
module countdown_timer_ctrl #(
    parameter int NUM_FIELDS = 2,
    parameter int FIELD_W    = 7,
    parameter int FIELD_MAX  = 59,
    parameter int TICK_DIV   = 50000000,
    parameter int FLASH_DIV  = 12500000,
    parameter int FLASH_SECS = 10
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              clear,
    input  logic                                              set,
    input  logic                                              startStop,
    input  logic [FIELD_W-1:0]                                swValue,
    output logic [NUM_FIELDS*FIELD_W-1:0]                     timeBus,
    output logic [((NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1)-1:0] editIdx,
    output logic [NUM_FIELDS-1:0]                             fieldSet,
    output logic [2:0]                                        state,
    output logic                                              running,
    output logic                                              isTimeFlat,
    output logic                                              flashOn
);

    localparam int IDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int FCNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
`ifdef FLASH_TIMEOUT_EN
    localparam int SECS_W = $clog2(FLASH_SECS + 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLASH = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [NUM_FIELDS*FIELD_W-1:0]   time_q, time_d, dec_time;
    logic [IDX_W-1:0]                edit_q, edit_d;
    logic [NUM_FIELDS-1:0]           fs_q, fs_d;
    logic [PRE_W-1:0]                presc_q, presc_d;
    logic [FCNT_W-1:0]               fcnt_q, fcnt_d;
    logic                            flash_q, flash_d;
    logic                            run_q, flat_q;
    logic                            tick, borrow, dec_zero;
    logic [FIELD_W-1:0]              load_value;
`ifdef FLASH_TIMEOUT_EN
    logic [SECS_W-1:0]               secs_q, secs_d;
`endif

    // Switch entries above the field maximum saturate rather than wrap.
    assign load_value = (swValue > FIELD_W'(FIELD_MAX)) ? FIELD_W'(FIELD_MAX) : swValue;

    // Next-state logic: prescaler, borrow-chain decrement, FSM transitions and strobes.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        edit_d   = edit_q;
        fs_d     = '0;
        presc_d  = presc_q;
        fcnt_d   = fcnt_q;
        flash_d  = 1'b0;
        tick     = 1'b0;
        dec_time = time_q;
        borrow   = 1'b1;
`ifdef FLASH_TIMEOUT_EN
        secs_d   = secs_q;
`endif

        // Ripple the borrow upward; a zero field wraps to the maximum and passes it on.
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (borrow) begin
                if (time_q[k*FIELD_W +: FIELD_W] == '0) begin
                    dec_time[k*FIELD_W +: FIELD_W] = FIELD_W'(FIELD_MAX);
                end else begin
                    dec_time[k*FIELD_W +: FIELD_W] = time_q[k*FIELD_W +: FIELD_W] - FIELD_W'(1);
                    borrow = 1'b0;
                end
            end
        end
        dec_zero = (dec_time == '0);

        // The prescaler only advances while counting down or alarming; READY keeps the partial second.
        if (state_q == ST_RUN || state_q == ST_FLASH) begin
            if (presc_q == PRE_W'(TICK_DIV - 1)) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end

        if (clear) begin
            state_d = ST_IDLE;
            time_d  = '0;
            edit_d  = '0;
            presc_d = '0;
            fcnt_d  = '0;
`ifdef FLASH_TIMEOUT_EN
            secs_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (set) begin
                        state_d = ST_SET;
                        edit_d  = '0;
                    end
                end
                ST_SET: begin
                    if (set) begin
                        time_d[edit_q*FIELD_W +: FIELD_W] = load_value;
                        fs_d[edit_q] = 1'b1;
                        if (edit_q == IDX_W'(NUM_FIELDS - 1)) begin
                            state_d = ST_READY;
                            edit_d  = '0;
                        end else begin
                            edit_d = edit_q + IDX_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    if (startStop && !flat_q) begin
                        state_d = ST_RUN;
                    end else if (set) begin
                        state_d = ST_SET;
                        edit_d  = '0;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        time_d = dec_time;
                        if (dec_zero) begin
                            state_d = ST_FLASH;
                            fcnt_d  = '0;
                            flash_d = 1'b1;
`ifdef FLASH_TIMEOUT_EN
                            secs_d  = '0;
`endif
                        end else if (startStop) begin
                            state_d = ST_READY;
                        end
                    end else if (startStop) begin
                        state_d = ST_READY;
                    end
                end
                ST_FLASH: begin
                    if (startStop || set) begin
                        state_d = ST_IDLE;
                        presc_d = '0;
                    end
`ifdef FLASH_TIMEOUT_EN
                    else if (tick && (secs_q == SECS_W'(FLASH_SECS - 1))) begin
                        state_d = ST_IDLE;
                        presc_d = '0;
                    end
`endif
                    else begin
                        flash_d = flash_q;
                        if (fcnt_q == FCNT_W'(FLASH_DIV - 1)) begin
                            fcnt_d  = '0;
                            flash_d = ~flash_q;
                        end else begin
                            fcnt_d = fcnt_q + FCNT_W'(1);
                        end
`ifdef FLASH_TIMEOUT_EN
                        if (tick) begin
                            secs_d = secs_q + SECS_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            edit_q  <= '0;
            fs_q    <= '0;
            presc_q <= '0;
            fcnt_q  <= '0;
            flash_q <= 1'b0;
            run_q   <= 1'b0;
            flat_q  <= 1'b1;
`ifdef FLASH_TIMEOUT_EN
            secs_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            edit_q  <= edit_d;
            fs_q    <= fs_d;
            presc_q <= presc_d;
            fcnt_q  <= fcnt_d;
            flash_q <= flash_d;
            run_q   <= (state_d == ST_RUN);
            flat_q  <= (time_d == '0);
`ifdef FLASH_TIMEOUT_EN
            secs_q  <= secs_d;
`endif
        end
    end

    assign timeBus    = time_q;
    assign editIdx    = edit_q;
    assign fieldSet   = fs_q;
    assign state      = state_q;
    assign running    = run_q;
    assign isTimeFlat = flat_q;
    assign flashOn    = flash_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: table-driven vectors plus hand-written multi-cycle
// sequences; every driven vector queues its expected outputs, which are popped
// and compared one time unit after the clock edge that produced them.
module tb_countdown_timer_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_READY = 2;
    localparam int S_RUN   = 3;
    localparam int S_FLASH = 4;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        set;
    logic        startStop;
    logic [6:0]  sw_value;
    logic [13:0] time_bus;
    logic [0:0]  edit_idx;
    logic [1:0]  field_set;
    logic [2:0]  state;
    logic        running;
    logic        is_time_flat;
    logic        flash_on;

    typedef struct {
        string       tag;
        logic        clr;
        logic        st;
        logic        ss;
        logic [6:0]  sw;
        logic [2:0]  e_state;
        logic [13:0] e_time;
        logic [0:0]  e_edit;
        logic [1:0]  e_fs;
        logic        e_run;
        logic        e_flat;
        logic        e_flash;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[16];
    int   vectors;
    int   miscompares;

    countdown_timer_ctrl #(
        .NUM_FIELDS(2),
        .FIELD_W(7),
        .FIELD_MAX(59),
        .TICK_DIV(4),
        .FLASH_DIV(2),
        .FLASH_SECS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .set(set),
        .startStop(startStop),
        .swValue(sw_value),
        .timeBus(time_bus),
        .editIdx(edit_idx),
        .fieldSet(field_set),
        .state(state),
        .running(running),
        .isTimeFlat(is_time_flat),
        .flashOn(flash_on)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(string tag, logic clr, logic st, logic ss, int sw,
                                int e_state, int f1, int f0, int e_edit, int e_fs, logic e_flash);
        vec_t v;
        v.tag     = tag;
        v.clr     = clr;
        v.st      = st;
        v.ss      = ss;
        v.sw      = 7'(sw);
        v.e_state = 3'(e_state);
        v.e_time  = {7'(f1), 7'(f0)};
        v.e_edit  = 1'(e_edit);
        v.e_fs    = 2'(e_fs);
        v.e_run   = (e_state == S_RUN);
        v.e_flat  = (f1 == 0) && (f0 == 0);
        v.e_flash = e_flash;
        return v;
    endfunction

    task automatic checkOutput();
        vec_t v;
        logic bad;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, required one queued");
            return;
        end
        v = sb.pop_front();
        vectors++;
        bad = 1'b0;
        if (state !== v.e_state) begin
            bad = 1'b1;
            $display("[TB] FAIL %s state: got %0d required %0d", v.tag, state, v.e_state);
        end
        if (time_bus !== v.e_time) begin
            bad = 1'b1;
            $display("[TB] FAIL %s timeBus: got {%0d,%0d} required {%0d,%0d}", v.tag,
                     time_bus[13:7], time_bus[6:0], v.e_time[13:7], v.e_time[6:0]);
        end
        if (edit_idx !== v.e_edit) begin
            bad = 1'b1;
            $display("[TB] FAIL %s editIdx: got %0d required %0d", v.tag, edit_idx, v.e_edit);
        end
        if (field_set !== v.e_fs) begin
            bad = 1'b1;
            $display("[TB] FAIL %s fieldSet: got %b required %b", v.tag, field_set, v.e_fs);
        end
        if (running !== v.e_run) begin
            bad = 1'b1;
            $display("[TB] FAIL %s running: got %b required %b", v.tag, running, v.e_run);
        end
        if (is_time_flat !== v.e_flat) begin
            bad = 1'b1;
            $display("[TB] FAIL %s isTimeFlat: got %b required %b", v.tag, is_time_flat, v.e_flat);
        end
        if (flash_on !== v.e_flash) begin
            bad = 1'b1;
            $display("[TB] FAIL %s flashOn: got %b required %b", v.tag, flash_on, v.e_flash);
        end
        if (bad) miscompares++;
    endtask

    task automatic applyStimulus(input vec_t v);
        clear     = v.clr;
        set       = v.st;
        startStop = v.ss;
        sw_value  = v.sw;
        sb.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        clear     = 1'b0;
        set       = 1'b0;
        startStop = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        clear       = 1'b0;
        set         = 1'b0;
        startStop   = 1'b0;
        sw_value    = '0;

        tbl[0]  = mk("enter_set",    0, 1, 0,   0, S_SET,   0,  0, 0, 2'b00, 0);
        tbl[1]  = mk("load_f0",      0, 1, 0,   5, S_SET,   0,  5, 1, 2'b01, 0);
        tbl[2]  = mk("load_f1",      0, 1, 0,   1, S_READY, 1,  5, 0, 2'b10, 0);
        tbl[3]  = mk("ready_hold",   0, 0, 0,   0, S_READY, 1,  5, 0, 2'b00, 0);
        tbl[4]  = mk("reenter_set",  0, 1, 0,   0, S_SET,   1,  5, 0, 2'b00, 0);
        tbl[5]  = mk("saturate_f0",  0, 1, 0, 100, S_SET,   1, 59, 1, 2'b01, 0);
        tbl[6]  = mk("load_f1_zero", 0, 1, 0,   0, S_READY, 0, 59, 0, 2'b10, 0);
        tbl[7]  = mk("reenter_set2", 0, 1, 0,   0, S_SET,   0, 59, 0, 2'b00, 0);
        tbl[8]  = mk("zero_f0",      0, 1, 0,   0, S_SET,   0,  0, 1, 2'b01, 0);
        tbl[9]  = mk("zero_f1",      0, 1, 0,   0, S_READY, 0,  0, 0, 2'b10, 0);
        tbl[10] = mk("ss_zero_time", 0, 0, 1,   0, S_READY, 0,  0, 0, 2'b00, 0);
        tbl[11] = mk("clear_ready",  1, 0, 0,   0, S_IDLE,  0,  0, 0, 2'b00, 0);
        tbl[12] = mk("ss_in_idle",   0, 0, 1,   0, S_IDLE,  0,  0, 0, 2'b00, 0);
        tbl[13] = mk("enter_set3",   0, 1, 0,   0, S_SET,   0,  0, 0, 2'b00, 0);
        tbl[14] = mk("ss_in_set",    0, 0, 1,   0, S_SET,   0,  0, 0, 2'b00, 0);
        tbl[15] = mk("clear_over_set", 1, 1, 0, 7, S_IDLE,  0,  0, 0, 2'b00, 0);

        // Reset values while reset is held low.
        #23;
        sb.push_back(mk("reset_state", 0, 0, 0, 0, S_IDLE, 0, 0, 0, 2'b00, 0));
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
        end

        // Borrow across fields, run to expiry.
        applyStimulus(mk("b_set",    0, 1, 0, 0, S_SET,   0, 0, 0, 2'b00, 0));
        applyStimulus(mk("b_f0",     0, 1, 0, 0, S_SET,   0, 0, 1, 2'b01, 0));
        applyStimulus(mk("b_f1",     0, 1, 0, 1, S_READY, 1, 0, 0, 2'b10, 0));
        applyStimulus(mk("b_start",  0, 0, 1, 0, S_RUN,   1, 0, 0, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk("b_prescale", 0, 0, 0, 0, S_RUN, 1, 0, 0, 2'b00, 0));
        end
        applyStimulus(mk("b_borrow", 0, 0, 0, 0, S_RUN,   0, 59, 0, 2'b00, 0));
        idleCycles(231);
        applyStimulus(mk("b_last_sec", 0, 0, 0, 0, S_RUN, 0, 1, 0, 2'b00, 0));
        idleCycles(3);
        applyStimulus(mk("b_expire", 0, 0, 0, 0, S_FLASH, 0, 0, 0, 2'b00, 1));
`ifdef FLASH_TIMEOUT_EN
        for (int k = 1; k <= 12; k++) begin
            if (k < 12)
                applyStimulus(mk("flash_timeout", 0, 0, 0, 0, S_FLASH, 0, 0, 0, 2'b00, ((k >> 1) & 1) == 0));
            else
                applyStimulus(mk("flash_timeout", 0, 0, 0, 0, S_IDLE, 0, 0, 0, 2'b00, 0));
        end
`else
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(mk("flash_hold", 0, 0, 0, 0, S_FLASH, 0, 0, 0, 2'b00, ((k >> 1) & 1) == 0));
        end
`endif
        applyStimulus(mk("flash_exit_ss", 0, 0, 1, 0, S_IDLE, 0, 0, 0, 2'b00, 0));

        // Pause keeps the partial prescaler count; a tick coinciding with stop still decrements.
        applyStimulus(mk("p_set",    0, 1, 0,  0, S_SET,   0, 0,  0, 2'b00, 0));
        applyStimulus(mk("p_f0",     0, 1, 0, 10, S_SET,   0, 10, 1, 2'b01, 0));
        applyStimulus(mk("p_f1",     0, 1, 0,  0, S_READY, 0, 10, 0, 2'b10, 0));
        applyStimulus(mk("p_start",  0, 0, 1,  0, S_RUN,   0, 10, 0, 2'b00, 0));
        applyStimulus(mk("p_run1",   0, 0, 0,  0, S_RUN,   0, 10, 0, 2'b00, 0));
        applyStimulus(mk("p_pause",  0, 0, 1,  0, S_READY, 0, 10, 0, 2'b00, 0));
        applyStimulus(mk("p_paused", 0, 0, 0,  0, S_READY, 0, 10, 0, 2'b00, 0));
        applyStimulus(mk("p_resume", 0, 0, 1,  0, S_RUN,   0, 10, 0, 2'b00, 0));
        applyStimulus(mk("p_run2",   0, 0, 0,  0, S_RUN,   0, 10, 0, 2'b00, 0));
        applyStimulus(mk("p_dec",    0, 0, 0,  0, S_RUN,   0, 9,  0, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk("p_count", 0, 0, 0, 0, S_RUN, 0, 9, 0, 2'b00, 0));
        end
        applyStimulus(mk("p_stop_on_tick", 0, 0, 1, 0, S_READY, 0, 8, 0, 2'b00, 0));
        applyStimulus(mk("p_clear",  1, 0, 0,  0, S_IDLE,  0, 0,  0, 2'b00, 0));

        // Stop pressed on the very tick that expires the timer.
        applyStimulus(mk("e_set",    0, 1, 0, 0, S_SET,   0, 0, 0, 2'b00, 0));
        applyStimulus(mk("e_f0",     0, 1, 0, 1, S_SET,   0, 1, 1, 2'b01, 0));
        applyStimulus(mk("e_f1",     0, 1, 0, 0, S_READY, 0, 1, 0, 2'b10, 0));
        applyStimulus(mk("e_start",  0, 0, 1, 0, S_RUN,   0, 1, 0, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk("e_count", 0, 0, 0, 0, S_RUN, 0, 1, 0, 2'b00, 0));
        end
        applyStimulus(mk("e_ss_final_tick", 0, 0, 1, 0, S_FLASH, 0, 0, 0, 2'b00, 1));
        applyStimulus(mk("flash_exit_set", 0, 1, 0, 0, S_IDLE, 0, 0, 0, 2'b00, 0));

        // Set ignored in RUN, clear aborts the run.
        applyStimulus(mk("c_set",    0, 1, 0, 0, S_SET,   0, 0, 0, 2'b00, 0));
        applyStimulus(mk("c_f0",     0, 1, 0, 3, S_SET,   0, 3, 1, 2'b01, 0));
        applyStimulus(mk("c_f1",     0, 1, 0, 2, S_READY, 2, 3, 0, 2'b10, 0));
        applyStimulus(mk("c_start",  0, 0, 1, 0, S_RUN,   2, 3, 0, 2'b00, 0));
        applyStimulus(mk("c_set_in_run", 0, 1, 0, 9, S_RUN, 2, 3, 0, 2'b00, 0));
        applyStimulus(mk("c_clear_run",  1, 0, 0, 0, S_IDLE, 0, 0, 0, 2'b00, 0));

        // Reset pulled low asynchronously while alarming.
        applyStimulus(mk("r_set",    0, 1, 0, 0, S_SET,   0, 0, 0, 2'b00, 0));
        applyStimulus(mk("r_f0",     0, 1, 0, 1, S_SET,   0, 1, 1, 2'b01, 0));
        applyStimulus(mk("r_f1",     0, 1, 0, 0, S_READY, 0, 1, 0, 2'b10, 0));
        applyStimulus(mk("r_start",  0, 0, 1, 0, S_RUN,   0, 1, 0, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk("r_count", 0, 0, 0, 0, S_RUN, 0, 1, 0, 2'b00, 0));
        end
        applyStimulus(mk("r_expire", 0, 0, 0, 0, S_FLASH, 0, 0, 0, 2'b00, 1));
        applyStimulus(mk("r_flash",  0, 0, 0, 0, S_FLASH, 0, 0, 0, 2'b00, 1));
        #2;
        reset = 1'b0;
        #1;
        sb.push_back(mk("r_async_reset", 0, 0, 0, 0, S_IDLE, 0, 0, 0, 2'b00, 0));
        checkOutput();
        @(posedge clk);
        #1;
        sb.push_back(mk("r_reset_held", 0, 0, 0, 0, S_IDLE, 0, 0, 0, 2'b00, 0));
        checkOutput();
        reset = 1'b1;
        applyStimulus(mk("r_after_reset", 0, 0, 0, 0, S_IDLE, 0, 0, 0, 2'b00, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
